// File: rtl/grid_frame_streamer.sv
// Reads the Game-of-Life grid out of the frame BRAM and streams it as AXI4-Stream video.
// One current word plus one prefetch word keep tvalid continuous; at most one BRAM read is in flight.
module grid_frame_streamer #(
  parameter int          H_RES     = 1280,
  parameter int          V_RES     = 720,
  parameter int          WORD_W    = 32,
  parameter int          ADDR_W    = 15,
  parameter logic [23:0] ALIVE_RGB = 24'hFFFFFF,
  parameter logic [23:0] DEAD_RGB  = 24'h000000
) (
  input  logic              out_stream_aclk,
  input  logic              rst,
  input  logic              enable,
  input  logic              calc_flag,
  output logic [ADDR_W-1:0] read_addr,
  output logic              read_en,
  input  logic [WORD_W-1:0] read_data,
  output logic [31:0]       out_stream_tdata,
  output logic              out_stream_tvalid,
  input  logic              out_stream_tready,
  output logic              out_stream_tuser,
  output logic              out_stream_tlast,
  output logic              frame_busy,
  output logic              frame_done
);

  localparam int TOTAL_WORDS = V_RES * H_RES / WORD_W;
  localparam int X_W   = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W   = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int B_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] cur_word, pf_word;
  logic              cur_vld, pf_vld, ret_pending;
  logic [B_W-1:0]    bit_cnt;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [CNT_W-1:0]  issued;

  logic hs, word_end, last_pix, cur_free, pf_take, start, issue;

  assign hs       = cur_vld && out_stream_tready;
  assign word_end = hs && (bit_cnt == B_W'(WORD_W - 1));
  assign last_pix = hs && (x == X_W'(H_RES - 1)) && (y == Y_W'(V_RES - 1));
  assign cur_free = !cur_vld || word_end;
  assign pf_take  = pf_vld && cur_free;
  assign start    = (state == IDLE) && enable && !calc_flag;
  // ret_pending covers the cycle the data is on read_data, so one outstanding read at most
  assign issue    = (state == STREAM) && !read_en && !ret_pending &&
                    (!pf_vld || pf_take) && (issued < CNT_W'(TOTAL_WORDS));

  assign out_stream_tvalid = cur_vld;
  assign out_stream_tdata  = cur_vld ? {8'h00, (cur_word[0] ? ALIVE_RGB : DEAD_RGB)} : 32'h0;
  assign out_stream_tuser  = cur_vld && (x == '0) && (y == '0);
  assign out_stream_tlast  = cur_vld && (x == X_W'(H_RES - 1));

  always_comb begin
    state_nxt  = state;
    frame_busy = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = STREAM;
      STREAM: begin
        frame_busy = 1'b1;
        if (last_pix) state_nxt = DONE;
      end
      DONE: begin
        frame_busy = 1'b1;
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge out_stream_aclk) begin
    if (rst) begin
      state       <= IDLE;
      read_en     <= 1'b0;
      read_addr   <= '0;
      issued      <= '0;
      ret_pending <= 1'b0;
      cur_word    <= '0;
      cur_vld     <= 1'b0;
      pf_word     <= '0;
      pf_vld      <= 1'b0;
      bit_cnt     <= '0;
      x           <= '0;
      y           <= '0;
    end else begin
      state       <= state_nxt;
      read_en     <= start || issue;
      ret_pending <= read_en;

      if (start) begin
        read_addr <= '0;
        issued    <= CNT_W'(1);
      end else if (issue) begin
        read_addr <= issued[ADDR_W-1:0];
        issued    <= issued + CNT_W'(1);
      end

      // Current word: refill from prefetch first, else straight from the returning read
      if (cur_free) begin
        bit_cnt <= '0;
        if (pf_vld) begin
          cur_word <= pf_word;
          cur_vld  <= 1'b1;
        end else if (ret_pending) begin
          cur_word <= read_data;
          cur_vld  <= 1'b1;
        end else begin
          cur_vld  <= 1'b0;
        end
      end else if (hs) begin
        cur_word <= cur_word >> 1;
        bit_cnt  <= bit_cnt + B_W'(1);
      end

      if (ret_pending && !(cur_free && !pf_vld)) begin
        pf_word <= read_data;
        pf_vld  <= 1'b1;
      end else if (pf_take) begin
        pf_vld  <= 1'b0;
      end

      if (start) begin
        x <= '0;
        y <= '0;
      end else if (hs) begin
        if (x == X_W'(H_RES - 1)) begin
          x <= '0;
          if (y != Y_W'(V_RES - 1)) y <= y + Y_W'(1);
        end else begin
          x <= x + X_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_grid_frame_streamer.sv
// Scoreboard bench for grid_frame_streamer on a 64x4 grid; expected pixels are derived from the grid contents.
module tb_grid_frame_streamer;
  localparam int H    = 64;
  localparam int V    = 4;
  localparam int WW   = 32;
  localparam int AW   = 15;
  localparam int NW   = H * V / WW;
  localparam int NPIX = H * V;

  logic          clk = 1'b0;
  logic          rst, enable, calc_flag;
  logic [AW-1:0] read_addr;
  logic          read_en;
  logic [WW-1:0] read_data;
  logic [31:0]   tdata;
  logic          tvalid, tready, tuser, tlast;
  logic          frame_busy, frame_done;

  always #5 clk = ~clk;

  grid_frame_streamer #(
    .H_RES(H), .V_RES(V), .WORD_W(WW), .ADDR_W(AW),
    .ALIVE_RGB(24'hFFFFFF), .DEAD_RGB(24'h000000)
  ) dut (
    .out_stream_aclk  (clk),
    .rst              (rst),
    .enable           (enable),
    .calc_flag        (calc_flag),
    .read_addr        (read_addr),
    .read_en          (read_en),
    .read_data        (read_data),
    .out_stream_tdata (tdata),
    .out_stream_tvalid(tvalid),
    .out_stream_tready(tready),
    .out_stream_tuser (tuser),
    .out_stream_tlast (tlast),
    .frame_busy       (frame_busy),
    .frame_done       (frame_done)
  );

  logic [31:0] mem [NW];
  always @(posedge clk) if (read_en) read_data <= mem[int'(read_addr) % NW];

  typedef struct packed {
    logic [31:0] dat;
    logic        usr;
    logic        lst;
  } beat_t;

  beat_t exp_q[$];
  int    addr_q[$];
  int    tests = 0, fails = 0;
  int    beats = 0, done_cnt = 0, rd_cnt = 0, bubbles = 0;
  bit    nobubble_mode = 0, bp = 0;
  bit    prev_stall = 0;
  beat_t prev_beat;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference: pixel (x,y) is bit x%WW of word y*(H/WW)+x/WW
  task automatic load_and_expect(input int mode);
    for (int k = 0; k < NW; k++) begin
      case (mode)
        0:       mem[k] = 32'hA5A50000 | k;
        1:       mem[k] = $urandom;
        default: mem[k] = 32'hFFFFFFFF;
      endcase
      addr_q.push_back(k);
    end
    for (int yy = 0; yy < V; yy++)
      for (int xx = 0; xx < H; xx++) begin
        beat_t b;
        logic [31:0] w;
        w     = mem[yy * (H / WW) + xx / WW];
        b.dat = w[xx % WW] ? 32'h00FFFFFF : 32'h0;
        b.usr = (xx == 0) && (yy == 0);
        b.lst = (xx == H - 1);
        exp_q.push_back(b);
      end
  endtask

  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1 tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    beat_t cur;
    cur = '{dat: tdata, usr: tuser, lst: tlast};
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_tvalid", longint'(tvalid), 1);
        chk("stall_fields", longint'(cur), longint'(prev_beat));
      end
      if (read_en) begin
        rd_cnt++;
        if (addr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL read_addr: read of %0d issued, none required", read_addr);
        end else begin
          chk("read_addr", longint'(read_addr), longint'(addr_q.pop_front()));
        end
      end
      if (frame_done) done_cnt++;
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL beat: extra beat %0h, none required", cur);
        end else begin
          chk("beat", longint'(cur), longint'(exp_q.pop_front()));
        end
        beats++;
      end
      if (!tvalid && nobubble_mode && beats > 0 && beats < NPIX) bubbles++;
      prev_stall = tvalid && !tready;
      prev_beat  = cur;
    end
  end

  task automatic clear_stats();
    beats = 0; done_cnt = 0; rd_cnt = 0; bubbles = 0;
  endtask

  task automatic start_frame();
    @(negedge clk) enable = 1'b1;
    @(negedge clk) enable = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    while (done_cnt == 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({name, "_done_pulses"}, done_cnt, 1);
    chk({name, "_beats"}, beats, NPIX);
    chk({name, "_left"}, exp_q.size(), 0);
    chk({name, "_reads"}, rd_cnt, NW);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; calc_flag = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_read_en", read_en, 0);
    chk("rst_read_addr", read_addr, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_busy", frame_busy, 0);
    chk("rst_done", frame_done, 0);
    @(negedge clk) rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_reads", rd_cnt, 0);
    chk("idle_busy", frame_busy, 0);

    // Full frame, no backpressure
    clear_stats(); nobubble_mode = 1; bp = 0;
    load_and_expect(0);
    start_frame();
    wait_frame("frame_a");
    chk("frame_a_bubbles", bubbles, 0);
    nobubble_mode = 0;

    // Same frame under random backpressure
    clear_stats(); bp = 1;
    load_and_expect(0);
    start_frame();
    wait_frame("frame_bp");
    bp = 0;

    // Interlock with calc_flag
    clear_stats();
    load_and_expect(1);
    @(negedge clk) begin calc_flag = 1'b1; enable = 1'b1; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("interlock_busy", frame_busy, 0);
    end
    chk("interlock_reads", rd_cnt, 0);
    calc_flag = 1'b0;
    @(negedge clk);
    chk("release_read_en", read_en, 1);
    chk("release_addr", read_addr, 0);
    enable = 1'b0;
    wait_frame("frame_lock");

    // Reset in the middle of a frame
    clear_stats(); bp = 1;
    load_and_expect(1);
    start_frame();
    for (int n = 0; n < 5000 && beats < 101; n++) @(negedge clk);
    chk("midrst_reached", longint'(beats >= 101), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tvalid", tvalid, 0);
    chk("midrst_busy", frame_busy, 0);
    exp_q.delete(); addr_q.delete();
    rst = 1'b0; bp = 0;
    repeat (5) @(negedge clk);
    chk("midrst_quiet_tvalid", tvalid, 0);

    // All-alive frame after reset restarts at address 0 with tuser first
    clear_stats();
    load_and_expect(2);
    start_frame();
    wait_frame("frame_alive");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/grid_frame_streamer.md
Name: grid_frame_streamer

Overview:
- Reader-side counterpart of the next-state write path. Once the line iterator has written the Game-of-Life grid into the frame BRAM, this block reads the grid back word by word.
- It expands each cell bit to an RGB pixel and emits the frame on the AXI4-Stream video output: tuser marks start of frame, tlast marks end of line.
- It interlocks with the iterator through calc_flag and frame_busy, so a frame is never read while it is being rewritten.

Parameters:
- H_RES, 1280, cells (pixels) per row.
- V_RES, 720, rows per frame.
- WORD_W, 32, cells per BRAM word. H_RES must be a multiple of WORD_W.
- ADDR_W, 15, BRAM word-address width. Must satisfy 2^ADDR_W >= V_RES*H_RES/WORD_W.
- ALIVE_RGB, 24'hFFFFFF, pixel colour for a cell bit of 1.
- DEAD_RGB, 24'h000000, pixel colour for a cell bit of 0.

Ports:
- out_stream_aclk  input  1  sole clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  level; permits a new frame to start.
- calc_flag  input  1  high while the line iterator is computing or writing.
- read_addr  output  ADDR_W  BRAM read word address.
- read_en  output  1  BRAM read strobe.
- read_data  input  WORD_W  BRAM data, valid exactly 1 cycle after read_en.
- out_stream_tdata  output  32  {8'h00, RGB}.
- out_stream_tvalid  output  1  AXIS valid.
- out_stream_tready  input  1  AXIS ready.
- out_stream_tuser  output  1  start of frame.
- out_stream_tlast  output  1  end of line.
- frame_busy  output  1  high while in STREAM or DONE; the iterator must not start while this is high.
- frame_done  output  1  one-cycle pulse after the last pixel handshakes.

Behaviour:
- Reset values: read_en=0, read_addr=0, tvalid=0, tuser=0, tlast=0, tdata=0, frame_busy=0, frame_done=0.
- Reset clears all counters and buffers, and discards any in-flight read. Reset mid-frame returns the block to IDLE with no further beats.
- State machine:
  - IDLE: go to STREAM on the edge where enable && !calc_flag. Word and pixel counters reset to 0.
  - STREAM: go to DONE on the handshake of pixel (H_RES-1, V_RES-1).
  - DONE: assert frame_done for 1 cycle, then go to IDLE.
- calc_flag rising during STREAM is ignored; the interlock is the iterator's responsibility via frame_busy.
- Addressing: word k of the frame is at address k = row*(H_RES/WORD_W) + col_word, with k running 0 .. V_RES*H_RES/WORD_W - 1.
- Bit order: bit 0 of each word is the leftmost pixel.
- Buffering: a current-word shift register, plus one prefetch register with a valid flag.
- Read issue rule: issue a read when all of the following hold:
  - the prefetch register is empty or being consumed this cycle;
  - no read is in flight;
  - unread words remain.
  - At most one outstanding read.
- Returning read_data goes to the current register if that is empty, otherwise to the prefetch register.
- Start latency: with start sampled at edge E0:
  - read_en=1 with addr 0 in the cycle after E0;
  - the data is captured at E2;
  - tvalid rises after E2.
- Output timing:
  - tvalid is high whenever the current register holds unconsumed pixels.
  - A pixel is consumed on tvalid && tready.
  - When the last pixel of a word is consumed and the prefetch register is valid, that word moves to current in the same edge, giving no bubble.
  - With tready held high, tvalid stays continuously high from the first pixel to the last.
- Pixel fields:
  - tdata = bit ? ALIVE_RGB : DEAD_RGB.
  - tuser=1 only on pixel (0,0).
  - tlast=1 only on x = H_RES-1.
- AXIS rule: while tvalid && !tready, tdata, tuser and tlast are held stable. tvalid never drops without a handshake.
- Counters: x wraps H_RES-1→0 and increments y; y stops at V_RES-1.
- A simultaneous handshake and read return in the same edge must not lose or duplicate a word.

Test Plan:
- Reset values: with H_RES=64, V_RES=4, hold rst for 3 cycles → all outputs at reset values. Then apply enable=0 → stays IDLE, read_en never asserts.
- Full frame, no backpressure: H_RES=64, V_RES=4, BRAM word k = 32'hA5A50000|k, tready=1 → exactly 256 beats with tdata matching the bit→colour map LSB-first. tuser on beat 0 only. tlast on beats 63/127/191/255. No bubbles after the first beat. frame_done pulses once. read_en count = 8, addresses 0..7 in order.
- Random backpressure: tready random at 50% duty → identical beat sequence to the previous test, with tdata, tuser and tlast stable during every stall.
- Interlock: calc_flag=1 with enable=1 for 20 cycles → no read_en, frame_busy=0. Drop calc_flag → read_en with addr 0 on the next cycle.
- Reset mid-frame: assert rst after beat 100 → tvalid=0 in the following cycle. Next frame restarts at addr 0 with tuser on its first beat.
- Default parameters: 1280x720 all-alive grid → 921600 beats of 32'h00FFFFFF, 720 tlast, 1 tuser.
